adc_uart_framer: RTL and testbench
==================================

Name: adc_uart_framer

Overview:
- Downstream consumer of the four ADC channel holding registers (out_reg_1..out_reg_4 of the ADC capture top).
- On a send request, snapshots all four channel bytes into a fixed frame and serialises it over a UART 8N1 transmitter.
- Frame: header byte, ch1, ch2, ch3, ch4, plus an optional XOR checksum byte.
- Provides the link from the ADC acquisition path to the host serial port.

Parameters:
- CLK_DIV, 434: clock cycles per UART bit (50 MHz / 115200). Legal range ≥ 2.
- HEADER, 8'hA5: first byte of every frame.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- ch1  input  8  channel 0 byte (from out_reg_1).
- ch2  input  8  channel 1 byte (from out_reg_2).
- ch3  input  8  channel 2 byte (from out_reg_3).
- ch4  input  8  channel 3 byte (from out_reg_4).
- send  input  1  frame request; sampled only in IDLE.
- tx  output  1  UART serial out; idles high.
- busy  output  1  high while a frame is in flight.
- frame_done  output  1  one-cycle pulse after the last stop bit completes.

Behaviour:
Reset:
- reset low forces, asynchronously: tx=1, busy=0, frame_done=0, state=IDLE.
- Baud, bit and byte counters clear to 0. Shadow registers clear to 0.

Registers and state machine:
- All outputs are registered.
- FSM states: IDLE, START, DATA, STOP.
- Baud counter counts 0..CLK_DIV-1. Bit counter counts 0..7. Byte index counts 0..NBYTES-1.
- NBYTES = 5, or 6 when the optional feature is compiled in.

IDLE:
- tx=1, busy=0.
- On the first edge where send=1, at that same edge:
  - ch1..ch4 are latched into shadow registers.
  - byte index = 0, busy <= 1, tx <= 0 (start bit of HEADER), state <= START.
  - Baud counter restarts from 0; it is not free-running.

Bit timing:
- Every bit (start, data, stop) holds tx stable for exactly CLK_DIV cycles.
- START -> DATA after CLK_DIV cycles.
- DATA sends bits LSB first. After bit 7's CLK_DIV cycles -> STOP (tx=1).
- STOP lasts CLK_DIV cycles, then:
  - If byte index < NBYTES-1: increment byte index, go to START immediately. No inter-byte gap.
  - Otherwise: state <= IDLE, busy <= 0, frame_done <= 1 for one cycle.

Byte order and latency:
- Byte order: HEADER, shadow ch1, ch2, ch3, ch4 [, checksum].
- Frame length: 10*NBYTES*CLK_DIV cycles from the accepting edge to busy falling (50*CLK_DIV base, 60*CLK_DIV with checksum).

Boundary conditions:
- send while busy=1 is ignored; no queueing.
- send held high continuously: a new frame is accepted on the edge after frame_done, so one idle-high cycle separates frames.
- ch1..ch4 changes during a frame do not affect it; only the snapshot is transmitted.
- reset asserted mid-frame aborts the frame immediately: tx=1 and no frame_done pulse.
- On reset release, the block waits in IDLE for a new send.

Optional Feature:
- Macro: ADC_UART_CHECKSUM_EN.
- Defined: a sixth byte is appended, equal to HEADER ^ ch1 ^ ch2 ^ ch3 ^ ch4 computed over the shadow values. NBYTES = 6.
- Not defined: 5-byte frame, and no checksum logic is instantiated.

Test Plan:
All cases use CLK_DIV=4 and feature off unless stated.
- Reset: hold reset=0 with send=1 toggling -> tx=1, busy=0, frame_done=0 throughout.
- Basic frame: ch1..ch4 = 12, 34, 56, 78; pulse send -> bytes A5 12 34 56 78 decoded LSB-first with 8N1 framing.
  - busy high for exactly 200 cycles.
  - frame_done pulses once, on the cycle busy falls.
- Checksum: same stimulus with ADC_UART_CHECKSUM_EN -> bytes A5 12 34 56 78 AD; busy high for 240 cycles.
- Snapshot and ignored send: change ch1 to FF and pulse send during byte 2 -> frame still carries 12; no second frame starts; busy falls at cycle 200.
- Back-to-back: hold send=1 for 500 cycles -> consecutive frames, each starting one cycle after the previous frame_done, with tx=1 in the gap cycle.
- Mid-frame reset: assert reset at cycle 73 of a frame -> tx=1 and busy=0 immediately; no frame_done. After release, a new send yields a full correct frame.

Source files
------------

// File: rtl/adc_uart_framer.sv
//------------------------------------------------------------------------------
// adc_uart_framer
//
// Takes a snapshot of the four ADC channel holding registers when a send
// request arrives. Sends them to the host as one fixed frame over a UART 8N1
// transmitter:
//   HEADER, ch1, ch2, ch3, ch4 [, checksum]
// Each byte has one start bit (0), eight data bits sent LSB first, and one
// stop bit (1). Every bit lasts CLK_DIV clock cycles. There is no gap between
// bytes.
//
// Optional feature (compile-time macro ADC_UART_CHECKSUM_EN):
//   When defined, a sixth byte is added to the frame. It is
//   HEADER ^ ch1 ^ ch2 ^ ch3 ^ ch4, computed over the snapshot values.
//   When not defined, the frame is 5 bytes and no checksum logic exists.
//
// Parameters:
//   CLK_DIV    clock cycles per UART bit (>= 2); 434 = 50 MHz / 115200
//   HEADER     first byte of every frame
//
// Ports:
//   clock      system clock, all logic on posedge
//   reset      asynchronous, active-low reset
//   ch1..ch4   channel bytes from out_reg_1..out_reg_4
//   send       frame request, only looked at while idle
//   tx         UART serial output, idles high
//   busy       high while a frame is being sent
//   frame_done one-cycle pulse on the cycle after the last stop bit ends
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module adc_uart_framer #(
    parameter int          CLK_DIV = 434,
    parameter logic [7:0]  HEADER  = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ch1,
    input  logic [7:0] ch2,
    input  logic [7:0] ch3,
    input  logic [7:0] ch4,
    input  logic       send,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

`ifdef ADC_UART_CHECKSUM_EN
    localparam int NBYTES = 6;
`else
    localparam int NBYTES = 5;
`endif

    localparam int                BAUD_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [2:0]        LAST_BYTE = 3'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [2:0]        byte_idx;
    logic [7:0]        shadow_1;
    logic [7:0]        shadow_2;
    logic [7:0]        shadow_3;
    logic [7:0]        shadow_4;
    logic [7:0]        shift_reg;
    logic [7:0]        cur_byte;
    logic              bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);

`ifdef ADC_UART_CHECKSUM_EN
    logic [7:0] checksum;
    assign checksum = HEADER ^ shadow_1 ^ shadow_2 ^ shadow_3 ^ shadow_4;
`endif

    // Selects the byte that the next START -> DATA transition will load.
    always_comb begin
        // NOTE: default assignment first so every path drives cur_byte and no latch is inferred.
        cur_byte = HEADER;
        case (byte_idx)
            3'd1:    cur_byte = shadow_1;
            3'd2:    cur_byte = shadow_2;
            3'd3:    cur_byte = shadow_3;
            3'd4:    cur_byte = shadow_4;
`ifdef ADC_UART_CHECKSUM_EN
            3'd5:    cur_byte = checksum;
`endif
            default: cur_byte = HEADER;
        endcase
    end

    // Single FSM. tx, busy and frame_done are registered here, so the start
    // bit of the header appears on the same edge that accepts the request.
    // NOTE: non-blocking assignments throughout, because every register here is updated together on the clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            shadow_1   <= '0;
            shadow_2   <= '0;
            shadow_3   <= '0;
            shadow_4   <= '0;
            shift_reg  <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    if (send) begin
                        shadow_1 <= ch1;
                        shadow_2 <= ch2;
                        shadow_3 <= ch3;
                        shadow_4 <= ch4;
                        byte_idx <= '0;
                        busy     <= 1'b1;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        tx        <= cur_byte[0];
                        shift_reg <= {1'b0, cur_byte[7:1]};
                        state     <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            tx        <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (byte_idx < LAST_BYTE) begin
                            // The next start bit begins right away, so there is no inter-byte gap.
                            byte_idx <= byte_idx + 1'b1;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_uart_framer.sv
//------------------------------------------------------------------------------
// tb_adc_uart_framer
//
// Directed bench for adc_uart_framer with CLK_DIV = 4. It follows the build's
// ADC_UART_CHECKSUM_EN setting. The bench decodes the serial line by sampling
// tx in the middle of each bit slot. It compares that result with frames
// computed by hand.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_adc_uart_framer;

    localparam int CLK_DIV = 4;
`ifdef ADC_UART_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif
    localparam int FRAME_CYC = 10 * NB * CLK_DIV;

    localparam int EV_NONE  = 0;
    localparam int EV_SNAP  = 1;
    localparam int EV_RESET = 2;

    logic       clock;
    logic       reset;
    logic [7:0] ch1, ch2, ch3, ch4;
    logic       send;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;

    // Hand-computed frame: A5 ^ 12 ^ 34 ^ 56 ^ 78 = AD.
    logic [7:0] exp_b [6] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAD};

    adc_uart_framer #(
        .CLK_DIV (CLK_DIV),
        .HEADER  (8'hA5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ch1        (ch1),
        .ch2        (ch2),
        .ch3        (ch3),
        .ch4        (ch4),
        .send       (send),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called 1 ns after the accepting edge. Steps through the frame one cycle
    // at a time and samples tx in the middle of each bit slot. It can also
    // inject a snapshot/ignored-send event or a mid-frame reset at evt_cyc.
    task automatic run_frame(input string tag, input int evt_kind, input int evt_cyc);
        logic slot [60];
        int   cyc;
        int   done_cnt;
        bit   aborted;
        logic [7:0] rx;
        cyc      = 0;
        done_cnt = 0;
        aborted  = 1'b0;
        foreach (slot[i]) slot[i] = 1'bx;
        while (busy === 1'b1 && cyc < 1000 && !aborted) begin
            if (evt_kind == EV_SNAP && cyc == evt_cyc) begin
                ch1  = 8'hFF;
                send = 1'b1;
            end
            if (evt_kind == EV_SNAP && cyc == evt_cyc + 1) send = 1'b0;
            if (evt_kind == EV_RESET && cyc == evt_cyc) begin
                reset = 1'b0;
                #1;
                check({tag, "_abort_tx"}, tx, 1'b1);
                check({tag, "_abort_busy"}, busy, 1'b0);
                check({tag, "_abort_done"}, frame_done, 1'b0);
                aborted = 1'b1;
            end else begin
                if (cyc % CLK_DIV == CLK_DIV / 2 && cyc / CLK_DIV < 60) slot[cyc / CLK_DIV] = tx;
                if (frame_done === 1'b1) done_cnt++;
                tick();
                cyc++;
            end
        end
        if (!aborted) begin
            check({tag, "_busy_cycles"}, cyc, FRAME_CYC);
            check({tag, "_done_on_fall"}, frame_done, 1'b1);
            check({tag, "_no_early_done"}, done_cnt, 0);
            for (int b = 0; b < NB; b++) begin
                for (int i = 0; i < 8; i++) rx[i] = slot[b * 10 + 1 + i];
                check($sformatf("%s_b%0d_start", tag, b), slot[b * 10], 1'b0);
                check($sformatf("%s_b%0d_data", tag, b), rx, exp_b[b]);
                check($sformatf("%s_b%0d_stop", tag, b), slot[b * 10 + 9], 1'b1);
            end
        end
    endtask

    // Raises send for one edge and checks that the start bit appears at once.
    task automatic accept(input string tag);
        send = 1'b1;
        tick();
        send = 1'b0;
        check({tag, "_accept_busy"}, busy, 1'b1);
        check({tag, "_accept_tx"}, tx, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        send  = 1'b0;
        ch1 = 8'h12; ch2 = 8'h34; ch3 = 8'h56; ch4 = 8'h78;

        // Reset held with send toggling: outputs must stay at their idle values.
        for (int i = 0; i < 8; i++) begin
            send = ~send;
            tick();
            check($sformatf("rst_tx_%0d", i), tx, 1'b1);
            check($sformatf("rst_busy_%0d", i), busy, 1'b0);
            check($sformatf("rst_done_%0d", i), frame_done, 1'b0);
        end
        send = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check("idle_busy", busy, 1'b0);
        check("idle_tx", tx, 1'b1);

        // Basic frame.
        accept("basic");
        run_frame("basic", EV_NONE, 0);
        tick();
        check("basic_done_1cyc", frame_done, 1'b0);

        // Change ch1 and send again during byte 2. The snapshot must be unchanged and the send ignored.
        accept("snap");
        run_frame("snap", EV_SNAP, 90);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("snap_no_refire_%0d", i), busy, 1'b0);
        end
        ch1 = 8'h12;

        // Back-to-back frames with send held high.
        send = 1'b1;
        tick();
        for (int f = 0; f < 2; f++) begin
            check($sformatf("b2b%0d_accept_busy", f), busy, 1'b1);
            run_frame($sformatf("b2b%0d", f), EV_NONE, 0);
            check($sformatf("b2b%0d_gap_tx", f), tx, 1'b1);
            check($sformatf("b2b%0d_gap_busy", f), busy, 1'b0);
            tick();
        end
        send = 1'b0;
        check("b2b2_accept_busy", busy, 1'b1);
        check("b2b2_accept_tx", tx, 1'b0);
        run_frame("b2b2", EV_NONE, 0);

        // Mid-frame reset at cycle 73. No frame_done may follow, and the block must recover.
        tick();
        accept("abort");
        run_frame("abort", EV_RESET, 73);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("abort_hold_done_%0d", i), frame_done, 1'b0);
            check($sformatf("abort_hold_tx_%0d", i), tx, 1'b1);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("abort_wait_busy_%0d", i), busy, 1'b0);
            check($sformatf("abort_wait_done_%0d", i), frame_done, 1'b0);
        end
        accept("recover");
        run_frame("recover", EV_NONE, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
